// File: rtl/clk_gen_if.sv
// Divisor-programming bus for clk_gen: write strobe, channel select, value and
// per-channel pending-write status.
interface clk_gen_if #(
  parameter int CNT_W  = 32,
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] div_busy;

  modport master (output div_wr, div_ch, div_val, input  div_busy);
  modport slave  (input  div_wr, div_ch, div_val, output div_busy);
endinterface

// File: rtl/clk_gen.sv
// Multi-channel clock divider with glitch-free runtime divisor updates.
// Define CLK_GEN_STEP_EN to enable run/halt/single-step control of channel 0.

module clk_gen_ch #(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             hold_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             tc_fall_o,
  output logic             idle_o,
  output logic             div_zero_o
);
  logic [CNT_W-1:0] div_q, div_d, pend_q, pend_d, cnt_q, cnt_d;
  logic             pv_q, pv_d, tog_q, tog_d, tick_q, tick_d;
  logic             tc;

  assign tc         = (div_q != '0) && (cnt_q == div_q - CNT_W'(1));
  assign tc_fall_o  = ~hold_i && tc && tog_q;
  assign idle_o     = ~tog_q && (cnt_q == '0);
  assign div_zero_o = (div_q == '0);

  always_comb begin
    div_d  = div_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    cnt_d  = cnt_q;
    tog_d  = tog_q;
    tick_d = 1'b0;
    if (hold_i || div_q == '0) begin
      // frozen channel: nothing to protect, take a pending divisor at once
      cnt_d = '0;
      tog_d = 1'b0;
      if (pv_q) begin
        div_d = pend_q;
        pv_d  = 1'b0;
      end
    end else if (tc) begin
      cnt_d  = '0;
      tog_d  = ~tog_q;
      tick_d = ~tog_q;
      // only swap at the falling toggle so the output never shows a runt high
      if (tog_q && pv_q) begin
        div_d = pend_q;
        pv_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (wr_i) begin
      pend_d = val_i;
      pv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= CNT_W'(DEFAULT_DIV);
      pend_q <= '0;
      pv_q   <= 1'b0;
      cnt_q  <= '0;
      tog_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      cnt_q  <= cnt_d;
      tog_q  <= tog_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = tog_q;
  assign tick_o = tick_q;
  assign busy_o = pv_q;
endmodule

module clk_gen #(
  parameter int CNT_W       = 32,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic              clk_in,
  input  logic              reset_n,
  clk_gen_if.slave          dbus,
  input  logic              halt,
  input  logic              step,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              halted,
  output logic              step_done,
  output logic              led
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] hold, busy, tc_fall, idle, div_zero;
  logic              hold0, led_q;
  logic              unused_st;

  // a select beyond NUM_CH-1 matches no channel and is dropped
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign hold[i] = (i == 0) ? hold0 : 1'b0;
    clk_gen_ch #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
      .hold_i     (hold[i]),
      .wr_i       (dbus.div_wr && (dbus.div_ch == CH_W'(i))),
      .val_i      (dbus.div_val),
      .clk_o      (clk_out[i]),
      .tick_o     (tick[i]),
      .busy_o     (busy[i]),
      .tc_fall_o  (tc_fall[i]),
      .idle_o     (idle[i]),
      .div_zero_o (div_zero[i])
    );
  end

  assign dbus.div_busy = busy;

`ifdef CLK_GEN_STEP_EN
  typedef enum logic [1:0] {RUN, HALTING, HALTED, STEP} state_e;
  state_e state_q, state_d;
  logic   step_done_q, step_done_d;

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    unique case (state_q)
      RUN:     if (halt) state_d = HALTING;
      HALTING: if (!halt)                      state_d = RUN;
               else if (tc_fall[0] || idle[0]) state_d = HALTED;
      HALTED:  if (step)       state_d = STEP;
               else if (!halt) state_d = RUN;
      STEP:    if (div_zero[0] || tc_fall[0]) begin
                 state_d     = HALTED;
                 step_done_d = 1'b1;
               end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_done_q <= step_done_d;
    end
  end

  assign hold0     = (state_q == HALTED);
  assign halted    = hold0;
  assign step_done = step_done_q;
  assign unused_st = ^{tc_fall, idle, div_zero};
`else
  assign hold0     = 1'b0;
  assign halted    = 1'b0;
  assign step_done = 1'b0;
  assign unused_st = ^{tc_fall, idle, div_zero, halt, step};
`endif

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) led_q <= 1'b0;
    else          led_q <= clk_out[0];
  end

  assign led = led_q;
endmodule
